// File: rtl/keypad_scanner_nxm.sv
// Matrix keypad scanner for a ROWS x COLS keypad: column strobing, whole-scan debounce,
// and a first-word-fall-through event FIFO carrying press/release codes.
module keypad_scanner_nxm #(
    parameter  int ROWS       = 4,
    parameter  int COLS       = 4,
    parameter  int SCAN_DIV   = 50000,
    parameter  int DEB_SCANS  = 4,
    parameter  int FIFO_DEPTH = 8,
    localparam int KW         = $clog2(ROWS * COLS),
    localparam int CW         = $clog2(FIFO_DEPTH + 1)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [ROWS-1:0] row,
    output logic [COLS-1:0] col,
    output logic [KW-1:0]   key_code,
    output logic            key_release,
    output logic            key_valid,
    input  logic            key_ready,
    output logic [CW-1:0]   fifo_count,
    output logic            multi_key,
    output logic            overflow,
    input  logic            clr_overflow
);

    localparam int DIVW = $clog2(SCAN_DIV);
    localparam int COLW = $clog2(COLS);
    localparam int ROWW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam int DCW  = $clog2(DEB_SCANS + 1);
    localparam int PW   = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        PRESS_DEB,
        HELD,
        REL_DEB
    } state_t;

    logic [ROWS-1:0] rowMeta_q, rowSync_q;
    logic [DIVW-1:0] divCnt_q;
    logic [COLW-1:0] colIdx_q;
    logic [1:0]      accHits_q;
    logic [KW-1:0]   accCode_q;
    logic            multi_q;

    logic            termCnt, scanEnd;
    logic [1:0]      colHits;
    logic [ROWW-1:0] firstRow;
    logic [KW-1:0]   colCode;
    logic [2:0]      hitSum;
    logic [1:0]      scanHits;
    logic [KW-1:0]   scanCode;

    state_t          state_q, state_d;
    logic [DCW-1:0]  debCnt_q, debCnt_d;
    logic [KW-1:0]   cand_q, cand_d;
    logic            push, pushRel;

    logic [KW:0]     mem_q [FIFO_DEPTH];
    logic [PW-1:0]   wrPtr_q, rdPtr_q;
    logic [CW-1:0]   count_q;
    logic            overflow_q;
    logic            pop, full, accept, drop;
    logic [KW:0]     head;

    // Rows are asynchronous pins; idle (pulled-up) level is all ones.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rowMeta_q <= '1;
            rowSync_q <= '1;
        end else begin
            rowMeta_q <= row;
            rowSync_q <= rowMeta_q;
        end
    end

    assign termCnt = (divCnt_q == DIVW'(SCAN_DIV - 1));
    assign scanEnd = termCnt && (colIdx_q == COLW'(COLS - 1));

    always_comb begin
        colHits  = 2'd0;
        firstRow = '0;
        for (int r = ROWS - 1; r >= 0; r--) begin
            if (!rowSync_q[r]) begin
                firstRow = ROWW'(r);
                colHits  = (colHits == 2'd0) ? 2'd1 : 2'd2;
            end
        end
    end

    assign colCode = KW'(int'(colIdx_q) * ROWS + int'(firstRow));
    assign hitSum  = {1'b0, accHits_q} + {1'b0, colHits};

    // Fold the current column into the running scan totals; first key wins in scan order.
    always_comb begin
        scanHits = (hitSum >= 3'd2) ? 2'd2 : hitSum[1:0];
        scanCode = accCode_q;
        if ((accHits_q == 2'd0) && (colHits != 2'd0)) begin
            scanCode = colCode;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            divCnt_q  <= '0;
            colIdx_q  <= '0;
            accHits_q <= '0;
            accCode_q <= '0;
            multi_q   <= 1'b0;
        end else begin
            divCnt_q <= termCnt ? '0 : divCnt_q + 1'b1;
            if (termCnt) begin
                colIdx_q <= (colIdx_q == COLW'(COLS - 1)) ? '0 : colIdx_q + 1'b1;
                if (scanEnd) begin
                    accHits_q <= '0;
                    accCode_q <= '0;
                    multi_q   <= (scanHits == 2'd2);
                end else begin
                    accHits_q <= scanHits;
                    accCode_q <= scanCode;
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            debCnt_q <= '0;
            cand_q   <= '0;
        end else begin
            state_q  <= state_d;
            debCnt_q <= debCnt_d;
            cand_q   <= cand_d;
        end
    end

    // Debounce acts only on completed scans; while held, extra keys are ignored.
    always_comb begin
        state_d  = state_q;
        debCnt_d = debCnt_q;
        cand_d   = cand_q;
        push     = 1'b0;
        pushRel  = 1'b0;
        if (scanEnd) begin
            case (state_q)
                IDLE: begin
                    if (scanHits == 2'd1) begin
                        cand_d   = scanCode;
                        debCnt_d = DCW'(1);
                        state_d  = PRESS_DEB;
                    end
                end
                PRESS_DEB: begin
                    if ((scanHits == 2'd1) && (scanCode == cand_q)) begin
                        if (debCnt_q == DCW'(DEB_SCANS - 1)) begin
                            push     = 1'b1;
                            debCnt_d = '0;
                            state_d  = HELD;
                        end else begin
                            debCnt_d = debCnt_q + 1'b1;
                        end
                    end else begin
                        debCnt_d = '0;
                        state_d  = IDLE;
                    end
                end
                HELD: begin
                    if (scanHits == 2'd0) begin
                        debCnt_d = DCW'(1);
                        state_d  = REL_DEB;
                    end
                end
                REL_DEB: begin
                    if (scanHits == 2'd0) begin
                        if (debCnt_q == DCW'(DEB_SCANS - 1)) begin
                            push     = 1'b1;
                            pushRel  = 1'b1;
                            debCnt_d = '0;
                            state_d  = IDLE;
                        end else begin
                            debCnt_d = debCnt_q + 1'b1;
                        end
                    end else begin
                        debCnt_d = '0;
                        state_d  = HELD;
                    end
                end
                default: begin
                    debCnt_d = '0;
                    state_d  = IDLE;
                end
            endcase
        end
    end

    // A pop in the same cycle frees the slot, so a push into a full FIFO still lands.
    assign pop    = (count_q != '0) && key_ready;
    assign full   = (count_q == CW'(FIFO_DEPTH));
    assign accept = push && (!full || pop);
    assign drop   = push && full && !pop;

    always_ff @(posedge clk) begin
        if (accept) begin
            mem_q[wrPtr_q] <= {pushRel, cand_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wrPtr_q    <= '0;
            rdPtr_q    <= '0;
            count_q    <= '0;
            overflow_q <= 1'b0;
        end else begin
            if (accept) begin
                wrPtr_q <= wrPtr_q + 1'b1;
            end
            if (pop) begin
                rdPtr_q <= rdPtr_q + 1'b1;
            end
            case ({accept, pop})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
            if (drop) begin
                overflow_q <= 1'b1;
            end else if (clr_overflow) begin
                overflow_q <= 1'b0;
            end
        end
    end

    assign head        = mem_q[rdPtr_q];
    assign key_valid   = (count_q != '0);
    assign key_code    = key_valid ? head[KW-1:0] : '0;
    assign key_release = key_valid & head[KW];
    assign fifo_count  = count_q;
    assign multi_key   = multi_q;
    assign overflow    = overflow_q;
    assign col         = ~(COLS'(1) << colIdx_q);

endmodule

// File: tb/tb_keypad_scanner_nxm.sv
// Directed bench for keypad_scanner_nxm: two instances (FIFO depth 8 and 2) share one keypad
// model; expected values are hand-derived from the 32-cycle scan timing.
module tb_keypad_scanner_nxm;

    localparam int ROWS = 4;
    localparam int COLS = 4;
    localparam int SCAN = 32;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [15:0] keys;
    logic [3:0]  rowA, rowB, colA, colB;
    logic [3:0]  codeA, codeB;
    logic        relA, relB, validA, validB, readyA, readyB;
    logic        multiA, multiB, ovfA, ovfB, clrA, clrB;
    logic [3:0]  countA;
    logic [1:0]  countB;
    int          tbCyc;
    int          vectors = 0;
    int          miscompares = 0;

    always #5 clk = ~clk;

    keypad_scanner_nxm #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(8), .DEB_SCANS(4), .FIFO_DEPTH(8)
    ) dutA (
        .clk(clk), .rst_n(rst_n), .row(rowA), .col(colA),
        .key_code(codeA), .key_release(relA), .key_valid(validA), .key_ready(readyA),
        .fifo_count(countA), .multi_key(multiA), .overflow(ovfA), .clr_overflow(clrA)
    );

    keypad_scanner_nxm #(
        .ROWS(ROWS), .COLS(COLS), .SCAN_DIV(8), .DEB_SCANS(4), .FIFO_DEPTH(2)
    ) dutB (
        .clk(clk), .rst_n(rst_n), .row(rowB), .col(colB),
        .key_code(codeB), .key_release(relB), .key_valid(validB), .key_ready(readyB),
        .fifo_count(countB), .multi_key(multiB), .overflow(ovfB), .clr_overflow(clrB)
    );

    // Passive keypad: a closed key pulls its row low while its column is strobed.
    always_comb begin
        rowA = '1;
        rowB = '1;
        for (int c = 0; c < COLS; c++) begin
            for (int r = 0; r < ROWS; r++) begin
                if (keys[c*ROWS + r] && !colA[c]) rowA[r] = 1'b0;
                if (keys[c*ROWS + r] && !colB[c]) rowB[r] = 1'b0;
            end
        end
    end

    always @(posedge clk) begin
        if (!rst_n) tbCyc <= 0;
        else        tbCyc <= tbCyc + 1;
    end

    task automatic checkOutput(input string tag, input logic [31:0] observed,
                               input logic [31:0] expected);
        vectors++;
        if (observed !== expected) begin
            miscompares++;
            $display("[TB] FAIL %s: observed %0h, expected %0h", tag, observed, expected);
        end
    endtask

    task automatic applyStimulus(input logic [15:0] k, input int scans);
        keys = k;
        repeat (scans * SCAN) @(negedge clk);
    endtask

    task automatic alignScan();
        for (int i = 0; i < SCAN && (tbCyc % SCAN) != 0; i++) @(negedge clk);
    endtask

    task automatic doReset();
        keys  = '0;
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n  = 1'b0;
        keys   = '0;
        readyA = 1'b0;
        readyB = 1'b0;
        clrA   = 1'b0;
        clrB   = 1'b0;
        repeat (3) @(negedge clk);

        checkOutput("rst_col",      colA,   4'hE);
        checkOutput("rst_valid",    validA, 0);
        checkOutput("rst_count",    countA, 0);
        checkOutput("rst_code",     codeA,  0);
        checkOutput("rst_release",  relA,   0);
        checkOutput("rst_multi",    multiA, 0);
        checkOutput("rst_overflow", ovfA,   0);
        checkOutput("rst_countB",   countB, 0);
        rst_n = 1'b1;
        repeat (8) @(negedge clk);
        checkOutput("col_step", colA, 4'hD);
        alignScan();

        applyStimulus(16'h1 << 6, 3);
        checkOutput("press_early_count", countA, 0);
        applyStimulus(16'h1 << 6, 1);
        checkOutput("press_count",   countA, 1);
        checkOutput("press_valid",   validA, 1);
        checkOutput("press_code",    codeA,  6);
        checkOutput("press_release", relA,   0);
        applyStimulus(16'h1 << 6, 2);
        checkOutput("press_hold_count", countA, 1);
        checkOutput("press_multi",      multiA, 0);

        applyStimulus(16'h0, 3);
        checkOutput("rel_early_count", countA, 1);
        applyStimulus(16'h0, 1);
        checkOutput("rel_count", countA, 2);
        applyStimulus(16'h0, 1);
        checkOutput("rel_head_code", codeA, 6);
        checkOutput("rel_head_rel",  relA,  0);
        readyA = 1'b1;
        @(negedge clk);
        checkOutput("pop1_count", countA, 1);
        checkOutput("pop1_code",  codeA,  6);
        checkOutput("pop1_rel",   relA,   1);
        @(negedge clk);
        checkOutput("pop2_valid", validA, 0);
        readyA = 1'b0;
        alignScan();

        doReset();
        applyStimulus(16'h1 << 9, 2);
        applyStimulus(16'h0, 1);
        checkOutput("bounce_gap_count", countA, 0);
        applyStimulus(16'h1 << 9, 3);
        checkOutput("bounce_early_count", countA, 0);
        applyStimulus(16'h1 << 9, 1);
        checkOutput("bounce_count", countA, 1);
        checkOutput("bounce_code",  codeA,  9);
        checkOutput("bounce_rel",   relA,   0);

        doReset();
        applyStimulus(16'h8001, 1);
        checkOutput("multi_first", multiA, 1);
        applyStimulus(16'h8001, 5);
        checkOutput("multi_held",  multiA, 1);
        checkOutput("multi_count", countA, 0);
        applyStimulus(16'h0, 1);
        checkOutput("multi_clear", multiA, 0);
        readyA = 1'b1;
        applyStimulus(16'h0, 1);
        checkOutput("empty_pop_count", countA, 0);
        checkOutput("empty_pop_valid", validA, 0);
        readyA = 1'b0;

        doReset();
        applyStimulus(16'h1 << 5, 5);
        applyStimulus(16'h0, 5);
        checkOutput("ovf_full_count", countB, 2);
        checkOutput("ovf_not_yet",    ovfB,   0);
        applyStimulus(16'h1 << 5, 5);
        checkOutput("ovf_set", ovfB, 1);
        applyStimulus(16'h0, 5);
        checkOutput("ovf_count",     countB, 2);
        checkOutput("ovf_head_code", codeB,  5);
        checkOutput("ovf_head_rel",  relB,   0);
        checkOutput("deep_count",    countA, 4);
        clrB = 1'b1;
        @(negedge clk);
        clrB = 1'b0;
        checkOutput("ovf_cleared", ovfB, 0);
        alignScan();
        applyStimulus(16'h1 << 5, 3);
        repeat (SCAN - 1) @(negedge clk);
        readyB = 1'b1;
        @(negedge clk);
        readyB = 1'b0;
        checkOutput("full_pushpop_count", countB, 2);
        checkOutput("full_pushpop_ovf",   ovfB,   0);
        checkOutput("full_pushpop_rel",   relB,   1);
        checkOutput("full_pushpop_deep",  countA, 5);
        alignScan();

        doReset();
        applyStimulus(16'h1 << 6, 3);
        repeat (10) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        checkOutput("midrst_col",   colA,   4'hE);
        checkOutput("midrst_valid", validA, 0);
        checkOutput("midrst_count", countA, 0);
        checkOutput("midrst_code",  codeA,  0);
        checkOutput("midrst_multi", multiA, 0);
        checkOutput("midrst_ovf",   ovfA,   0);
        rst_n = 1'b1;
        applyStimulus(16'h1 << 6, 3);
        checkOutput("midrst_early_count", countA, 0);
        applyStimulus(16'h1 << 6, 1);
        checkOutput("midrst_press_count", countA, 1);
        checkOutput("midrst_press_code",  codeA,  6);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/keypad_scanner_nxm.md
# keypad_scanner_nxm

Parametrised matrix-keypad scanner for any ROWS×COLS keypad. It drives active-low column strobes and samples synchronised active-low rows. Each scan is debounced as a whole, and qualified press and release events are queued in a FIFO with a valid/ready interface. It sits between the keypad pins and the display/decode logic, replacing the fixed 4×4 decoder and separate debouncer path.

## Interface
- ROWS, 4, number of row inputs (≥1)
- COLS, 4, number of column outputs (≥2)
- SCAN_DIV, 50000, clk cycles each column is driven (≥4)
- DEB_SCANS, 4, consecutive identical full scans needed to qualify an event (≥2)
- FIFO_DEPTH, 8, event FIFO entries (power of 2, ≥2)
- KW (localparam), $clog2(ROWS*COLS), key code width
- clk  in  1  system clock, single clock domain
- rst_n  in  1  synchronous, active-low reset
- row  in  ROWS  keypad rows, active-low (pulled up), asynchronous
- col  out  COLS  column strobes, active-low one-hot
- key_code  out  KW  head event key code
- key_release  out  1  head event type: 0 = press, 1 = release
- key_valid  out  1  FIFO not empty; head event present
- key_ready  in  1  consumer accepts head event when key_valid=1
- fifo_count  out  $clog2(FIFO_DEPTH+1)  queued events
- multi_key  out  1  last completed scan saw ≥2 keys
- overflow  out  1  sticky: an event was dropped
- clr_overflow  in  1  clears overflow

## Operation
- Reset values: col=~1 (column 0 driven), key_valid=0, fifo_count=0, key_code=0, key_release=0, multi_key=0, overflow=0. FSM=IDLE. All counters=0.
- row passes through a 2-FF synchroniser, reset to all 1s.
- Dwell counter counts 0..SCAN_DIV-1. On the terminal count:
  - sample the synchronised rows for the current column;
  - then advance the column index, wrapping at COLS-1 to 0.
- Key code = col_index*ROWS + row_index.
- Per scan, the block accumulates a pressed-key count, saturating at 2, and the code of the first pressed key in scan order.
- Scan result after sampling column COLS-1:
  - NONE: 0 keys;
  - SINGLE(code): 1 key;
  - MULTI: ≥2 keys.
  - multi_key is updated at every scan end.
- Debounce FSM, evaluated once per scan end:
  - IDLE: on SINGLE, set cand=code, cnt=1, go to PRESS_DEB. Otherwise stay.
  - PRESS_DEB: SINGLE with the same code increments cnt. When cnt reaches DEB_SCANS, push {0,cand} and go to HELD. Any other result returns to IDLE with no event.
  - HELD: NONE sets cnt=1 and goes to REL_DEB. Otherwise stay; a second key or MULTI is ignored while held.
  - REL_DEB: NONE increments cnt. When cnt reaches DEB_SCANS, push {1,cand} and go to IDLE. Any other result returns to HELD.
- FIFO behaviour:
  - First-word-fall-through. key_code and key_release show the head entry whenever key_valid=1.
  - Pop occurs on key_valid && key_ready.
  - A push when full with no pop that cycle is dropped and sets overflow.
  - A push when full with a pop in the same cycle is accepted.
  - Pop while empty is ignored.
- overflow clears on clr_overflow=1. If a drop occurs in the same cycle, set wins.
- Pointers wrap modulo FIFO_DEPTH. fifo_count is exact, 0..FIFO_DEPTH.

## Timing
- Column period is SCAN_DIV cycles. Full scan is COLS*SCAN_DIV cycles.
- Rows are sampled SCAN_DIV-1 cycles after the column change; 2 of those cycles are synchroniser latency.
- Press event: pushed on the scan-end cycle of the DEB_SCANS-th consecutive matching scan. key_valid rises the next cycle.
- Release event: the same rule applies to DEB_SCANS consecutive NONE scans.
- Minimum key-down time to register a press is DEB_SCANS full scans. Pulses shorter than one scan may be missed.
- A handshake pops one entry per cycle. With continuous key_ready=1, each event is presented for exactly 1 cycle.
- rst_n=0 mid-scan or mid-debounce: on the next edge, everything returns to reset values; FIFO contents are discarded and no event is emitted.

## Test plan
- Press, clean: ROWS=COLS=4, SCAN_DIV=8, DEB_SCANS=4, key_ready=0. Hold col1/row2 for 6 scans -> exactly one entry {release=0, code=6}, key_valid=1, fifo_count=1. The push lands at the end of the 4th scan.
- Release, clean: continue from the held state of the previous scenario, then release for 5 scans -> second entry {1,6}, fifo_count=2. Pop both with key_ready=1 -> key_valid=0 two cycles later.
- Bounce: key 9 down 2 scans, up 1 scan, down 4 scans -> only one press event {0,9}, pushed after the 4th scan of the final run.
- Multi-key: keys 0 and 15 together for 6 scans from IDLE -> multi_key=1, no events. Release both -> multi_key=0 after the next scan.
- Overflow: FIFO_DEPTH=2, key_ready=0. Perform 2 press/release cycles (4 events) -> fifo_count=2, overflow=1, and the head is the first press. Pulse clr_overflow -> overflow=0.
- Reset mid-debounce: assert rst_n=0 during PRESS_DEB at cnt=3 -> col=~1 and all outputs at reset values next cycle. The key kept held after reset yields a press only after 4 fresh scans.
